// File: rtl/rv32i_types.sv
// Shared types and constants for the instruction/data cache arbiter.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INSTR,
    ARB_DATA
  } arb_state_t;

  localparam logic [3:0] ARB_IMBE = 4'b1111;

  // Encoding of the last-granted requester.
  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and load/store requests.
// ARB_RR_EN selects round-robin tie-break; otherwise data has fixed priority.
module arb_pick
  import rv32i_types::*;
(
  input  logic ireq,
  input  logic dreq,
  input  logic last_grant,
  output logic gnt_i,
  output logic gnt_d
);

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
`ifdef ARB_RR_EN
    if (ireq && dreq) begin
      gnt_d = (last_grant == GNT_INSTR);
      gnt_i = ~gnt_d;
    end else begin
      gnt_d = dreq;
      gnt_i = ireq;
    end
`else
    gnt_d = dreq;
    gnt_i = ireq & ~dreq;
`endif
  end

`ifndef ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates IF and MEM ports onto one registered shared memory port.
// Optional ARB_RR_EN enables round-robin tie-break with a last_grant flop.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [DATA_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [DATA_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [3:0]        dmem_mbe,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_mbe,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mbe_q, mem_mbe_d;
  logic              last_grant;
  logic              gnt_i, gnt_d;

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = GNT_INSTR;
`endif

  arb_pick u_arb_pick (
    .ireq       (imem_read),
    .dreq       (dmem_read | dmem_write),
    .last_grant (last_grant),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_mbe_d     = mem_mbe_q;
`ifdef ARB_RR_EN
    last_grant_d  = last_grant_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_d) begin
          state_d       = ARB_DATA;
          mem_write_d   = dmem_write;
          mem_read_d    = dmem_read & ~dmem_write;
          mem_address_d = dmem_address;
          mem_wdata_d   = dmem_wdata;
          mem_mbe_d     = dmem_mbe;
`ifdef ARB_RR_EN
          last_grant_d  = GNT_DATA;
`endif
        end else if (gnt_i) begin
          state_d       = ARB_INSTR;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = imem_address;
          mem_wdata_d   = '0;
          mem_mbe_d     = ARB_IMBE;
`ifdef ARB_RR_EN
          last_grant_d  = GNT_INSTR;
`endif
        end
      end
      // Requester lines still show the finished access here, so go idle
      // rather than re-arbitrating on stale requests.
      ARB_INSTR, ARB_DATA: begin
        if (mem_resp) begin
          state_d     = ARB_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_mbe_q     <= '0;
`ifdef ARB_RR_EN
      last_grant_q  <= GNT_INSTR;
`endif
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_mbe_q     <= mem_mbe_d;
`ifdef ARB_RR_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_mbe     = mem_mbe_q;

  always_comb begin
    imem_resp  = (state_q == ARB_INSTR) && mem_resp;
    dmem_resp  = (state_q == ARB_DATA) && mem_resp;
    imem_rdata = imem_resp ? mem_rdata : '0;
    dmem_rdata = dmem_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed table-driven bench for cache_arbiter plus contention/reset sequences.
module tb_cache_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_mbe     (dmem_mbe),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_mbe      (mem_mbe),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dm;
    logic        mr;
    logic [31:0] mrd;
    logic [135:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  function automatic logic [135:0] mk_out(logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                                          logic [3:0] mbe, logic irs, logic [31:0] ird,
                                          logic drs, logic [31:0] drd);
    return {rd, wr, a, wd, mbe, irs, ird, drs, drd};
  endfunction

  function automatic vec_t mk_vec(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                  logic [31:0] dwd, logic [3:0] dm, logic mr, logic [31:0] mrd,
                                  logic [135:0] exp);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dm = dm;
    v.mr = mr; v.mrd = mrd; v.exp = exp;
    return v;
  endfunction

  function automatic logic [135:0] act_out();
    return {mem_read, mem_write, mem_address, mem_wdata, mem_mbe,
            imem_resp, imem_rdata, dmem_resp, dmem_rdata};
  endfunction

  task automatic drive(input vec_t v);
    imem_read = v.ir; imem_address = v.ia;
    dmem_read = v.dr; dmem_write = v.dw; dmem_address = v.da;
    dmem_wdata = v.dwd; dmem_mbe = v.dm;
    mem_resp = v.mr; mem_rdata = v.mrd;
  endtask

  task automatic chk(input string nm, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simultaneous load and store from the MEM stage is illegal.
  always @(negedge clk) begin
    if (rst && dmem_read && dmem_write) begin
      n_bad++;
      $display("FAIL illegal_rw: dmem_read=%b dmem_write=%b expected not both", dmem_read,
               dmem_write);
    end
  end

  logic [135:0] z;
  logic         rr;
  vec_t         idle_v;

  initial begin
`ifdef ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    z = '0;
    idle_v = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, z);

    // Fetch: grant, resp on 3rd grant cycle
    tbl[0]  = mk_vec(1, 32'h60, 0, 0, 0, 0, 0, 0, 0, z);
    tbl[1]  = mk_vec(1, 32'h60, 0, 0, 0, 0, 0, 0, 0, mk_out(1, 0, 32'h60, 0, 4'hF, 0, 0, 0, 0));
    tbl[2]  = mk_vec(1, 32'h60, 0, 0, 0, 0, 0, 0, 0, mk_out(1, 0, 32'h60, 0, 4'hF, 0, 0, 0, 0));
    tbl[3]  = mk_vec(1, 32'h60, 0, 0, 0, 0, 0, 1, 32'h13,
                     mk_out(1, 0, 32'h60, 0, 4'hF, 1, 32'h13, 0, 0));
    tbl[4]  = mk_vec(0, 32'h60, 0, 0, 0, 0, 0, 0, 0, mk_out(0, 0, 32'h60, 0, 4'hF, 0, 0, 0, 0));
    // Store
    tbl[5]  = mk_vec(0, 0, 0, 1, 32'h100, 32'hAB00, 4'b0010, 0, 0,
                     mk_out(0, 0, 32'h60, 0, 4'hF, 0, 0, 0, 0));
    tbl[6]  = mk_vec(0, 0, 0, 1, 32'h100, 32'hAB00, 4'b0010, 0, 0,
                     mk_out(0, 1, 32'h100, 32'hAB00, 4'b0010, 0, 0, 0, 0));
    tbl[7]  = mk_vec(0, 0, 0, 1, 32'h100, 32'hAB00, 4'b0010, 1, 32'h55,
                     mk_out(0, 1, 32'h100, 32'hAB00, 4'b0010, 0, 0, 1, 32'h55));
    tbl[8]  = mk_vec(0, 0, 0, 0, 32'h100, 32'hAB00, 4'b0010, 0, 0,
                     mk_out(0, 0, 32'h100, 32'hAB00, 4'b0010, 0, 0, 0, 0));
    // Load with address churn during the grant
    tbl[9]  = mk_vec(0, 0, 1, 0, 32'h200, 0, 4'hF, 0, 0,
                     mk_out(0, 0, 32'h100, 32'hAB00, 4'b0010, 0, 0, 0, 0));
    tbl[10] = mk_vec(0, 0, 1, 0, 32'h300, 0, 4'hF, 0, 0,
                     mk_out(1, 0, 32'h200, 0, 4'hF, 0, 0, 0, 0));
    tbl[11] = mk_vec(0, 0, 1, 0, 32'h300, 0, 4'hF, 1, 32'h1234,
                     mk_out(1, 0, 32'h200, 0, 4'hF, 0, 0, 1, 32'h1234));
    tbl[12] = mk_vec(0, 0, 0, 0, 32'h300, 0, 4'hF, 0, 0,
                     mk_out(0, 0, 32'h200, 0, 4'hF, 0, 0, 0, 0));
    // Stray response in IDLE
    tbl[13] = mk_vec(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                     mk_out(0, 0, 32'h200, 0, 4'hF, 0, 0, 0, 0));
    tbl[14] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, mk_out(0, 0, 32'h200, 0, 4'hF, 0, 0, 0, 0));

    rst = 1'b0;
    drive(idle_v);
    #12;
    chk("reset_values", act_out(), z);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), act_out(), tbl[i].exp);
      tick();
    end

    // Contention from reset: data first in both modes
    drive(idle_v);
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
    imem_read = 1; imem_address = 32'h80;
    dmem_read = 1; dmem_address = 32'h400; dmem_mbe = 4'hF;
    @(negedge clk);
    chk("cont_idle", {127'd0, mem_read}, 136'd0);
    tick();
    mem_resp = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("cont_first_addr", {103'd0, mem_read, mem_address}, {103'd0, 1'b1, 32'h400});
    chk("cont_first_resp", {134'd0, imem_resp, dmem_resp}, {134'd0, 2'b01});
    tick();
    mem_resp = 0;
    @(negedge clk);
    chk("cont_bubble", {127'd0, mem_read}, 136'd0);
    tick();
    mem_resp = 1; mem_rdata = 32'h88;
    @(negedge clk);
    chk("cont_second_addr", {104'd0, mem_address}, {104'd0, rr ? 32'h80 : 32'h400});
    chk("cont_second_resp", {134'd0, imem_resp, dmem_resp}, {134'd0, rr, ~rr});
    tick();
    mem_resp = 0; dmem_read = 0;
    @(negedge clk);
    chk("cont_bubble2", {127'd0, mem_read}, 136'd0);
    tick();
    mem_resp = 1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("cont_instr_grant", {102'd0, mem_read, mem_address, imem_resp},
        {102'd0, 1'b1, 32'h80, 1'b1});
    tick();
    drive(idle_v);
    tick();

    // Reset while a fetch is outstanding
    imem_read = 1; imem_address = 32'h90;
    tick();
    tick();
    @(negedge clk);
    chk("rst_pre_grant", {103'd0, mem_read, mem_address}, {103'd0, 1'b1, 32'h90});
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_clear", act_out(), z);
    imem_read = 0; mem_resp = 1; mem_rdata = 32'hCAFE;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_late_resp", act_out(), z);
    tick();
    mem_resp = 0;
    @(negedge clk);
    chk("rst_stays_idle", act_out(), z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the pipeline's separate instruction and data memory ports onto one shared downstream memory/cache port. It accepts a fetch request (IF stage) and a load/store request (MEM stage), grants one at a time, and drives a registered request to the shared port. The response and read data are routed back only to the granted requester. It sits between the CPU datapath and the unified cache.

## Interface
Parameters:
- DATA_W, 32, width of address, read data and write data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- imem_read  in  1  instruction fetch request; held high until imem_resp.
- imem_address  in  DATA_W  fetch address.
- imem_rdata  out  DATA_W  fetch data; valid while imem_resp=1.
- imem_resp  out  1  fetch complete, one cycle.
- dmem_read  in  1  data load request; held until dmem_resp.
- dmem_write  in  1  data store request; held until dmem_resp.
- dmem_address  in  DATA_W  data word address.
- dmem_wdata  in  DATA_W  store data, already lane-shifted.
- dmem_mbe  in  4  store byte enables.
- dmem_rdata  out  DATA_W  load data; valid while dmem_resp=1.
- dmem_resp  out  1  data access complete, one cycle.
- mem_read  out  1  shared-port read request.
- mem_write  out  1  shared-port write request.
- mem_address  out  DATA_W  shared-port address.
- mem_wdata  out  DATA_W  shared-port write data.
- mem_mbe  out  4  shared-port byte enables.
- mem_rdata  in  DATA_W  shared-port read data.
- mem_resp  in  1  shared-port completion, one cycle.

## Operation
- FSM states: ARB_IDLE, ARB_INSTR, ARB_DATA. Reset state is ARB_IDLE.
- In ARB_IDLE, the block samples the request lines:
  - Data only pending (dmem_read|dmem_write): go to ARB_DATA.
  - Instruction only pending: go to ARB_INSTR.
  - Both pending: choose per the Configuration section.
  - Nothing pending: stay in ARB_IDLE.
- On grant, the block latches the winner's address, wdata and mbe, plus read/write intent, into output registers.
  - Instruction grant: mem_read=1, mem_write=0, mem_mbe=4'b1111, mem_wdata=0.
  - Data grant: mem_write=dmem_write. mem_read=dmem_read & ~dmem_write, so write wins if both are asserted; simultaneous read and write is illegal and the bench asserts on it.
- In ARB_INSTR or ARB_DATA, the latched request is held stable until mem_resp. Requester input changes are ignored during this time.
- When mem_resp=1 in a grant state:
  - The granted requester's resp is driven high that same cycle, with rdata passed through combinationally from mem_rdata.
  - mem_read and mem_write clear at the edge, and the FSM returns to ARB_IDLE.
- The block never re-arbitrates in the response cycle, because the requester's lines still reflect the completed request.
- The non-granted resp is always 0. Both rdata outputs are 0 when their resp is 0.
- mem_resp in ARB_IDLE is ignored.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_mbe=0, imem_resp=0, dmem_resp=0, imem_rdata=0, dmem_rdata=0, last_grant=INSTR.
- Latency: request seen in IDLE at cycle N → mem_read/mem_write high from cycle N+1. With a memory latency of L cycles, resp reaches the requester at cycle N+L. Best case (mem_resp in the first grant cycle) is resp at N+1.
- Back-to-back accesses have one IDLE bubble cycle between a resp and the next grant.
- If reset is asserted mid-grant, all outputs clear immediately (asynchronously) and the FSM enters IDLE. The abandoned downstream access is not completed, and a late mem_resp is ignored.
- All mem_* outputs come straight from registers. The resp and rdata outputs are combinational from state, mem_resp and mem_rdata.

## Configuration
- ARB_RR_EN defined: round-robin tie-break. When both requests are pending in IDLE, the requester that was not granted last wins. last_grant updates on every grant and resets to INSTR, so the first contended grant goes to data.
- ARB_RR_EN undefined: fixed priority, data always beats instruction. last_grant is not implemented.

## Structure
- In rv32i_types: the enum arb_state_t {ARB_IDLE, ARB_INSTR, ARB_DATA} and the constant ARB_IMBE = 4'b1111.
- One sub-module, arb_pick: a combinational winner select taking (ireq, dreq, last_grant) and producing the grant. Its round-robin path sits under ARB_RR_EN.

## Test plan
- Single fetch: imem_read=1, imem_address=0x60; mem_resp at the 3rd grant cycle with mem_rdata=0x00000013 → mem_read=1 with address 0x60 and mbe=4'hF; imem_resp=1 with imem_rdata=0x13 for exactly one cycle; dmem_resp stays 0.
- Store: dmem_write=1, addr=0x100, wdata=0xAB00, mbe=4'b0010 → mem_write=1 with these exact values held until mem_resp; mem_read=0; dmem_resp pulses.
- Contention: imem_read and dmem_read rise together.
  - Without ARB_RR_EN: data is granted first, instruction after one IDLE bubble.
  - With ARB_RR_EN: data first; after both are re-requested, instruction is granted next.
- Input churn: change dmem_address from 0x200 to 0x300 during a grant → mem_address stays 0x200 until resp.
- Reset mid-grant: drop rst while mem_read=1 → all outputs are 0 immediately. A mem_resp=1 in the first post-reset cycle produces no imem_resp or dmem_resp.
- Stray response: mem_resp=1 with mem_rdata=0xDEADBEEF in IDLE → both resp and rdata outputs stay 0 and the state is unchanged.
